uart_tx_fifo: RTL and testbench

//  - 8N1 UART transmitter with small transmit FIFO; serialises bytes onto TX, LSB first.
//  - Pairs with the segway UART receiver at the same baud: host/controller side queues

---
 rtl/uart_tx_fifo_if.sv | 22 ++
 rtl/uart_tx_fifo.sv | 148 ++++++++++++++
 tb/tb_uart_tx_fifo.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// Host-side bundle for uart_tx_fifo: byte push strobe, flag clear, status flags and serial line.
// The host drives through the master modport; the transmitter sits on the slave modport.
interface uart_tx_fifo_if;
  logic       trmt;
  logic [7:0] tx_data;
  logic       clr_done;
  logic       TX;
  logic       tx_done;
  logic       busy;
  logic       full;
  logic       ovf;

  modport master (
    output trmt, tx_data, clr_done,
    input  TX, tx_done, busy, full, ovf
  );

  modport slave (
    input  trmt, tx_data, clr_done,
    output TX, tx_done, busy, full, ovf
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter (8N1, LSB first) draining a small byte FIFO back-to-back without idle gaps.
// Define UART_TX_PARITY_EN to insert an even parity bit before the stop bit (11-bit frame).
module uart_tx_fifo #(
  parameter int BAUD_DIV   = 2604,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_fifo_if.slave bus
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam logic [12:0]      BAUD_RELOAD = 13'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] DEPTH_C     = CNT_W'(FIFO_DEPTH);
  localparam logic [3:0]       LAST_BIT    = 4'(NBITS - 1);

  typedef enum logic {IDLE, XMIT} state_e;

  state_e           state_q, state_d;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [NBITS-1:0] shift_q, shift_d;
  logic [12:0]      baud_cnt_q, baud_cnt_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic             tx_done_q, tx_done_d;
  logic             ovf_q, ovf_d;

  logic full, empty, push, pop, set_done;

  // Shift register image: start bit in [0], stop bit in [NBITS-1].
  function automatic logic [NBITS-1:0] frame_of(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
    return {1'b1, ^b, b, 1'b0};
`else
    return {1'b1, b, 1'b0};
`endif
  endfunction

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);
  assign push  = bus.trmt && !full;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    pop        = 1'b0;
    set_done   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_d    = XMIT;
          shift_d    = frame_of(mem_q[rd_ptr_q]);
          baud_cnt_d = BAUD_RELOAD;
          bit_cnt_d  = '0;
        end
      end
      XMIT: begin
        if (baud_cnt_q != '0) begin
          baud_cnt_d = baud_cnt_q - 13'd1;
        end else if (bit_cnt_q != LAST_BIT) begin
          shift_d    = {1'b1, shift_q[NBITS-1:1]};
          bit_cnt_d  = bit_cnt_q + 4'd1;
          baud_cnt_d = BAUD_RELOAD;
        end else if (!empty) begin
          // Stop bit done with more data queued: next start bit follows with no idle gap.
          pop        = 1'b1;
          shift_d    = frame_of(mem_q[rd_ptr_q]);
          baud_cnt_d = BAUD_RELOAD;
          bit_cnt_d  = '0;
        end else begin
          state_d   = IDLE;
          shift_d   = {1'b1, shift_q[NBITS-1:1]};
          bit_cnt_d = '0;
          set_done  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  // A clear beats an accepted push, which beats the end-of-queue set.
  always_comb begin
    tx_done_d = tx_done_q;
    if (bus.clr_done)  tx_done_d = 1'b0;
    else if (push)     tx_done_d = 1'b0;
    else if (set_done) tx_done_d = 1'b1;
    ovf_d = ovf_q;
    if (bus.clr_done)          ovf_d = 1'b0;
    else if (bus.trmt && full) ovf_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      shift_q    <= '1;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      tx_done_q  <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      shift_q    <= shift_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_done_q  <= tx_done_d;
      ovf_q      <= ovf_d;
    end
  end

  // NOTE: FIFO storage has no reset; count and pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.tx_data;
  end

  assign bus.TX      = shift_q[0];
  assign bus.tx_done = tx_done_q;
  assign bus.busy    = (state_q == XMIT) || !empty;
  assign bus.full    = full;
  assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a vector table of bytes with hand-computed line frames,
// plus hand sequences for burst, overflow, clear priority and mid-frame reset.
module tb_uart_tx_fifo;

  localparam int BAUD = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = BAUD * NB;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_fifo_if bus ();

  uart_tx_fifo #(.BAUD_DIV(BAUD), .FIFO_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // frame holds the 8N1 line bits in send order: [9] start, [8:1] data LSB first, [0] stop.
  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
    logic       par;
  } vec_t;

  vec_t vecs [10];
  int   sq [$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic wait_to(input int p);
    if (cyc > p) begin
      total++;
      bad++;
      $display("FAIL schedule: at cycle %0d, target %0d already passed", cyc, p);
    end
    while (cyc < p) @(negedge clk);
  endtask

  function automatic logic exp_bit(input int vi, input int b);
    if (b < 9) return vecs[vi].frame[9-b];
    if (NB == 11 && b == 9) return vecs[vi].par;
    return 1'b1;
  endfunction

  // Called at a negedge; the push lands on the next posedge, then tx_data is scrambled.
  task automatic drive_push(input logic [7:0] d);
    bus.trmt    = 1'b1;
    bus.tx_data = d;
    @(negedge clk);
    bus.trmt    = 1'b0;
    bus.tx_data = ~d;
  endtask

  // Frames in sq were queued with the first push on posedge n0; frame k starts at n0+1+k*FRAME.
  task automatic check_stream(input int n0, input string tag);
    int base;
    for (int k = 0; k < sq.size(); k++) begin
      base = n0 + 1 + FRAME * k;
      for (int b = 0; b < NB; b++) begin
        wait_to(base + BAUD * b + BAUD / 2);
        check($sformatf("%s f%0d bit%0d TX", tag, k, b), bus.TX, exp_bit(sq[k], b));
      end
      wait_to(base + FRAME - 1);
      check($sformatf("%s f%0d pre-end tx_done", tag, k), bus.tx_done, 0);
      check($sformatf("%s f%0d pre-end busy", tag, k), bus.busy, 1);
    end
    wait_to(n0 + 1 + FRAME * sq.size());
    check({tag, " end tx_done"}, bus.tx_done, 1);
    check({tag, " end busy"}, bus.busy, 0);
    check({tag, " end TX idle"}, bus.TX, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n0;

    vecs[0] = '{8'hA5, 10'b0101001011, 1'b0};
    vecs[1] = '{8'h55, 10'b0101010101, 1'b0};
    vecs[2] = '{8'h0F, 10'b0111100001, 1'b0};
    vecs[3] = '{8'hF0, 10'b0000011111, 1'b0};
    vecs[4] = '{8'h81, 10'b0100000011, 1'b0};
    vecs[5] = '{8'h3C, 10'b0001111001, 1'b0};
    vecs[6] = '{8'h00, 10'b0000000001, 1'b0};
    vecs[7] = '{8'hFF, 10'b0111111111, 1'b0};
    vecs[8] = '{8'h07, 10'b0111000001, 1'b1};
    vecs[9] = '{8'h03, 10'b0110000001, 1'b0};

    rst          = 1'b1;
    bus.trmt     = 1'b0;
    bus.tx_data  = 8'h00;
    bus.clr_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset TX", bus.TX, 1);
    check("reset busy", bus.busy, 0);
    check("reset tx_done", bus.tx_done, 0);
    check("reset full", bus.full, 0);
    check("reset ovf", bus.ovf, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single frames from the table, each from an idle, empty queue.
    for (int i = 0; i < 10; i++) begin
      n0 = cyc + 1;
      sq = '{i};
      drive_push(vecs[i].data);
      check($sformatf("v%0d latency TX still high", i), bus.TX, 1);
      check($sformatf("v%0d busy after push", i), bus.busy, 1);
      check_stream(n0, $sformatf("v%0d", i));
    end

    // Burst of four on consecutive cycles: the first pops immediately, so never full.
    @(negedge clk);
    n0 = cyc + 1;
    sq = '{1, 2, 3, 4};
    for (int i = 1; i <= 4; i++) drive_push(vecs[i].data);
    check("burst full stays low", bus.full, 0);
    check_stream(n0, "burst");

    // Six pushes: the fifth fills the queue, the sixth is dropped and flags overflow.
    @(negedge clk);
    n0 = cyc + 1;
    sq = '{0, 5, 6, 7, 8};
    drive_push(vecs[0].data);
    drive_push(vecs[5].data);
    drive_push(vecs[6].data);
    drive_push(vecs[7].data);
    check("ovf seq full after 4", bus.full, 0);
    drive_push(vecs[8].data);
    check("ovf seq full after 5", bus.full, 1);
    check("ovf seq ovf after 5", bus.ovf, 0);
    drive_push(vecs[9].data);
    check("ovf seq full after 6", bus.full, 1);
    check("ovf seq ovf after 6", bus.ovf, 1);
    check_stream(n0, "ovf");
    wait_to(cyc + FRAME);
    check("ovf dropped byte not sent TX", bus.TX, 1);
    check("ovf dropped byte not sent busy", bus.busy, 0);
    check("ovf sticky", bus.ovf, 1);
    bus.clr_done = 1'b1;
    @(negedge clk);
    bus.clr_done = 1'b0;
    check("clr_done ovf", bus.ovf, 0);
    check("clr_done tx_done", bus.tx_done, 0);

    // clr_done on the very edge the frame ends: the clear must win over the set.
    @(negedge clk);
    n0 = cyc + 1;
    drive_push(vecs[4].data);
    wait_to(n0 + FRAME);
    check("clr race before end busy", bus.busy, 1);
    bus.clr_done = 1'b1;
    @(negedge clk);
    bus.clr_done = 1'b0;
    check("clr race tx_done", bus.tx_done, 0);
    check("clr race busy", bus.busy, 0);

    // Reset during bit 3 of 0x3C with two more bytes queued: everything is abandoned.
    @(negedge clk);
    n0 = cyc + 1;
    drive_push(vecs[5].data);
    drive_push(vecs[0].data);
    drive_push(vecs[1].data);
    wait_to(n0 + 1 + 3 * BAUD + BAUD / 2);
    check("midreset bit3 TX", bus.TX, exp_bit(5, 3));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midreset TX", bus.TX, 1);
    check("midreset busy", bus.busy, 0);
    check("midreset full", bus.full, 0);
    check("midreset tx_done", bus.tx_done, 0);
    for (int i = 0; i < 10; i++) begin
      repeat (2 * BAUD) @(negedge clk);
      check($sformatf("midreset idle %0d TX", i), bus.TX, 1);
    end
    check("midreset final busy", bus.busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
